// File: rtl/fetch_redirect_ctrl.sv
// Prioritised PC-redirect controller between the hazard unit and the fetch stage.
// Optional misaligned-target fault: define FETCH_REDIRECT_MISALIGN_EN.
module fetch_redirect_ctrl #(
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [NUM_SRC*ADDR_W-1:0] req_addr,
  input  logic                      fetch_busy,
  input  logic                      stall_in,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      update_pc,
  output logic [ADDR_W-1:0]         update_addr,
  output logic                      flush,
  output logic                      stall,
  output logic                      misalign_fault
);

  localparam int unsigned SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FLUSH
  } state_e;

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [SRC_W-1:0]    pend_src_q,  pend_src_d;
  logic [3:0]          flush_cnt_q, flush_cnt_d;

  logic                win_valid;
  logic [SRC_W-1:0]    win_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic                preempt;
  logic                take;
  logic                misaligned;
  logic [ADDR_W-1:0]   issue_addr;

  // Lowest set index wins; scanning downwards lets the last hit be the winner.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_valid = 1'b1;
        win_idx   = SRC_W'(i);
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign preempt = win_valid && (win_idx < pend_src_q);

`ifdef FETCH_REDIRECT_MISALIGN_EN
  assign misaligned = |pend_addr_q[1:0];
  assign issue_addr = pend_addr_q;
`else
  assign misaligned = 1'b0;
  assign issue_addr = pend_addr_q & ~ADDR_W'(3);
`endif

  // NOTE: every output and next-state value gets a default first so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    pend_addr_d    = pend_addr_q;
    pend_src_d     = pend_src_q;
    flush_cnt_d    = flush_cnt_q;
    take           = 1'b0;
    grant          = '0;
    update_pc      = 1'b0;
    flush          = 1'b0;
    stall          = stall_in;
    misalign_fault = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          take    = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        flush = 1'b1;
        if (fetch_busy) begin
          stall = 1'b1;
        end else begin
          // stall_in is masked here so the PC load is never lost.
          stall = 1'b0;
          if (misaligned) begin
            misalign_fault = 1'b1;
            state_d        = S_IDLE;
          end else begin
            update_pc = 1'b1;
            if (FLUSH_CYCLES == 0) begin
              state_d = S_IDLE;
            end else begin
              state_d     = S_FLUSH;
              flush_cnt_d = FLUSH_INIT;
            end
          end
        end
        if (preempt) begin
          take    = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_q <= 4'd1) begin
          state_d = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
        if (preempt) begin
          take    = 1'b1;
          state_d = S_ISSUE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (take) begin
      grant       = NUM_SRC'(1) << win_idx;
      pend_addr_d = win_addr;
      pend_src_d  = win_idx;
    end

    // While reset is held nothing may be granted or issued.
    if (!nRST) begin
      grant          = '0;
      update_pc      = 1'b0;
      flush          = 1'b0;
      stall          = stall_in;
      misalign_fault = 1'b0;
    end
  end

  assign update_addr = update_pc ? issue_addr : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      pend_addr_q <= '0;
      pend_src_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_src_q  <= pend_src_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
